// File: rtl/matriculas_pkg.sv
// Shared definitions for the plate history store (historico_matriculas).
package matriculas_pkg;

    localparam int MATR_W_DEF = 24;

    typedef logic [MATR_W_DEF-1:0] matr_t;

    // Plate value 0 is reserved to mean "no plate" and is never stored.
    localparam matr_t MATR_NULA = '0;

endpackage

// File: rtl/hist_shift_reg.sv
// DEPTH x MATR_W shift store: newest entry enters slot 0 and older entries
// move up one slot. Provides a synchronous clear, a combinational indexed
// read (0 for an index past the last slot) and a flat view of all slots.
module hist_shift_reg
    import matriculas_pkg::*;
#(
    parameter int MATR_W = MATR_W_DEF,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    i_shift,
    input  logic                    i_clr,
    input  logic [MATR_W-1:0]       i_din,
    input  logic [IDX_W-1:0]        i_rd_idx,
    output logic [MATR_W-1:0]       o_rd_data,
    output logic [DEPTH*MATR_W-1:0] o_slots
);

    logic [MATR_W-1:0] r_slot [DEPTH];

    // Slot storage: clear wins over shift; the oldest slot falls off the top.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
        end else if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= '0;
        end else if (i_shift) begin
            r_slot[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) r_slot[k] <= r_slot[k-1];
        end
    end

    // Indexed read by compare so an index beyond DEPTH-1 yields 0.
    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(i_rd_idx) == k) o_rd_data = r_slot[k];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign o_slots[g*MATR_W +: MATR_W] = r_slot[g];
        end
    endgenerate

endmodule

// File: rtl/historico_matriculas.sv
// History of the last DEPTH distinct plates, newest in slot 0.
// Two-stage path: stage 1 registers the candidate, stage 2 decides
// accept / repeat / ignore and shifts the store.
// Optional build macro HIST_DEDUP_ALL_EN: a plate matching any occupied
// slot is a repeat; otherwise only the last accepted plate is compared.
module historico_matriculas
    import matriculas_pkg::*;
#(
    parameter int MATR_W = MATR_W_DEF,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH+1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [MATR_W-1:0] Matricula,
    input  logic              MatrVal,
    input  logic              Limpa,
    input  logic [IDX_W-1:0]  RdIdx,
    output logic [MATR_W-1:0] RdMatr,
    output logic              RdValid,
    output logic [MATR_W-1:0] Ultima,
    output logic [MATR_W-1:0] Penultima,
    output logic [CNT_W-1:0]  Count,
    output logic              Nova,
    output logic              Repetida
);

    logic [MATR_W-1:0]       r_s1_matr;
    logic                    r_s1_vld;
    logic [MATR_W-1:0]       r_last_matr;
    logic                    r_last_vld;
    logic [CNT_W-1:0]        r_count;
    logic                    r_nova;
    logic                    r_rep;
    logic [MATR_W-1:0]       r_rd_matr;
    logic                    r_rd_valid;

    logic                    w_null;
    logic                    w_dup;
    logic                    w_accept;
    logic                    w_repeat;
    logic [MATR_W-1:0]       w_rd_data;
    logic [DEPTH*MATR_W-1:0] w_slots;

    assign w_null = (r_s1_matr == MATR_W'(MATR_NULA));

`ifdef HIST_DEDUP_ALL_EN
    // Parallel compare of the stage-1 plate against every occupied slot.
    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(r_count) && w_slots[k*MATR_W +: MATR_W] == r_s1_matr)
                w_dup = 1'b1;
        end
    end
`else
    assign w_dup = r_last_vld && (r_s1_matr == r_last_matr);
`endif

    assign w_accept = r_s1_vld && !w_null && !w_dup && !Limpa;
    assign w_repeat = r_s1_vld && !w_null &&  w_dup && !Limpa;

    hist_shift_reg #(
        .MATR_W (MATR_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_store (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .i_shift   (w_accept),
        .i_clr     (Limpa),
        .i_din     (r_s1_matr),
        .i_rd_idx  (RdIdx),
        .o_rd_data (w_rd_data),
        .o_slots   (w_slots)
    );

    // Stage 1: sample the candidate every cycle, Limpa does not affect it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_matr <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_matr <= Matricula;
            r_s1_vld  <= MatrVal;
        end
    end

    // Stage 2: last-accepted tracking, occupancy and event pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_matr <= '0;
            r_last_vld  <= 1'b0;
            r_count     <= '0;
            r_nova      <= 1'b0;
            r_rep       <= 1'b0;
        end else if (Limpa) begin
            r_last_matr <= '0;
            r_last_vld  <= 1'b0;
            r_count     <= '0;
            r_nova      <= 1'b0;
            r_rep       <= 1'b0;
        end else begin
            r_nova <= w_accept;
            r_rep  <= w_repeat;
            if (w_accept) begin
                r_last_matr <= r_s1_matr;
                r_last_vld  <= 1'b1;
                if (r_count != CNT_W'(DEPTH)) r_count <= r_count + 1'b1;
            end
        end
    end

    // Registered read port; sees storage as it was before this edge's write.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_matr  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_matr  <= w_rd_data;
            r_rd_valid <= (int'(RdIdx) < int'(r_count));
        end
    end

    assign RdMatr    = r_rd_matr;
    assign RdValid   = r_rd_valid;
    assign Ultima    = w_slots[MATR_W-1:0];
    assign Penultima = w_slots[2*MATR_W-1:MATR_W];
    assign Count     = r_count;
    assign Nova      = r_nova;
    assign Repetida  = r_rep;

endmodule
